// File: rtl/lbm_pkg.sv
// Shared LBM definitions: D2Q9 direction indices, lattice vectors,
// opposite-direction map and Q3.13 constants used by collider and streamer.
package lbm_pkg;

  localparam int DATA_W = 16;
  localparam int N_DIR  = 9;

  localparam logic [3:0] DIR_NULL = 4'd0;
  localparam logic [3:0] DIR_N    = 4'd1;
  localparam logic [3:0] DIR_NE   = 4'd2;
  localparam logic [3:0] DIR_E    = 4'd3;
  localparam logic [3:0] DIR_SE   = 4'd4;
  localparam logic [3:0] DIR_S    = 4'd5;
  localparam logic [3:0] DIR_SW   = 4'd6;
  localparam logic [3:0] DIR_W    = 4'd7;
  localparam logic [3:0] DIR_NW   = 4'd8;

  // Q3.13: 1.0, 4/9, 1/9, 1/36
  localparam logic [DATA_W-1:0] Q_ONE = 16'h2000;
  localparam logic [DATA_W-1:0] Q_W0  = 16'h0E39;
  localparam logic [DATA_W-1:0] Q_W1  = 16'h038E;
  localparam logic [DATA_W-1:0] Q_W2  = 16'h00E4;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  function automatic logic signed [1:0] dir_dx(input logic [3:0] d);
    case (d)
      DIR_NE, DIR_E, DIR_SE: return 2'sd1;
      DIR_SW, DIR_W, DIR_NW: return -2'sd1;
      default:               return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [3:0] d);
    case (d)
      DIR_N, DIR_NE, DIR_NW: return 2'sd1;
      DIR_SE, DIR_S, DIR_SW: return -2'sd1;
      default:               return 2'sd0;
    endcase
  endfunction

  function automatic logic [3:0] dir_opp(input logic [3:0] d);
    case (d)
      DIR_N:   return DIR_S;
      DIR_NE:  return DIR_SW;
      DIR_E:   return DIR_W;
      DIR_SE:  return DIR_NW;
      DIR_S:   return DIR_N;
      DIR_SW:  return DIR_NE;
      DIR_W:   return DIR_E;
      DIR_NW:  return DIR_SE;
      default: return DIR_NULL;
    endcase
  endfunction

endpackage

// File: rtl/lbm_stream_addr.sv
// Destination of one population: periodic wrap, or with
// LBM_STREAMER_BOUNCE_BACK_EN half-way bounce-back at all four walls.
module lbm_stream_addr
  import lbm_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 64,
  parameter int X_W    = 6,
  parameter int Y_W    = 6
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [3:0]     dir,
  output logic [3:0]     plane,
  output logic [X_W-1:0] dest_x,
  output logic [Y_W-1:0] dest_y
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic              x_lo;
  logic              x_hi;
  logic              y_lo;
  logic              y_hi;
  logic [X_W-1:0]    wx;
  logic [Y_W-1:0]    wy;

  assign dx   = dir_dx(dir);
  assign dy   = dir_dy(dir);
  assign x_lo = (x == '0);
  assign x_hi = (x == X_MAX);
  assign y_lo = (y == '0);
  assign y_hi = (y == Y_MAX);

  // Periodic neighbour in x: edge compare selects the wrapped value
  always_comb begin
    wx = x;
    unique case (1'b1)
      (dx == 2'sd1):  wx = x_hi ? '0 : x + X_W'(1);
      (dx == -2'sd1): wx = x_lo ? X_MAX : x - X_W'(1);
      default:        wx = x;
    endcase
  end

  // Periodic neighbour in y
  always_comb begin
    wy = y;
    unique case (1'b1)
      (dy == 2'sd1):  wy = y_hi ? '0 : y + Y_W'(1);
      (dy == -2'sd1): wy = y_lo ? Y_MAX : y - Y_W'(1);
      default:        wy = y;
    endcase
  end

`ifdef LBM_STREAMER_BOUNCE_BACK_EN
  logic off_grid;

  assign off_grid = ((dx == 2'sd1)  && x_hi) ||
                    ((dx == -2'sd1) && x_lo) ||
                    ((dy == 2'sd1)  && y_hi) ||
                    ((dy == -2'sd1) && y_lo);

  // Leaving populations reflect into the opposite plane of the source cell
  always_comb begin
    plane  = dir;
    dest_x = wx;
    dest_y = wy;
    if (off_grid) begin
      plane  = dir_opp(dir);
      dest_x = x;
      dest_y = y;
    end
  end
`else
  assign plane  = dir;
  assign dest_x = wx;
  assign dest_y = wy;
`endif

endmodule

// File: rtl/lbm_streamer.sv
// Streaming writer: takes one cell of nine populations, writes each to its
// destination plane/cell. Option macro: LBM_STREAMER_BOUNCE_BACK_EN.
module lbm_streamer
  import lbm_pkg::*;
#(
  parameter int GRID_W = 64,
  parameter int GRID_H = 64,
  parameter int X_W    = 6,
  parameter int Y_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   f_in,
  output logic                  mem_we,
  output logic [4+Y_W+X_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [X_W-1:0]        cell_x,
  output logic [Y_W-1:0]        cell_y
);

  localparam int ADDR_W = 4 + Y_W + X_W;
  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            dir_q;
  logic [3:0]            dir_nx;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [9*DATA_W-1:0]   f_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  fd_q;
  logic                  accept;
  logic                  wr_ok;
  logic                  last;
  logic [3:0]            a_plane;
  logic [X_W-1:0]        a_x;
  logic [Y_W-1:0]        a_y;

  assign accept = in_valid && in_ready;
  assign wr_ok  = (state_q == ST_WRITE) && mem_ready;
  assign last   = wr_ok && (dir_q == DIR_NW);
  assign dir_nx = accept ? DIR_NULL : dir_q + 4'd1;

  lbm_stream_addr #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_addr (
    .x      (x_q),
    .y      (y_q),
    .dir    (dir_nx),
    .plane  (a_plane),
    .dest_x (a_x),
    .dest_y (a_y)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: clr overrides everything
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = ST_WRITE;
        ST_WRITE: if (last)   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    mem_we   = (state_q == ST_WRITE);
    busy     = (state_q == ST_WRITE);
  end

  // Datapath: population shift register, address/data regs, raster
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= DIR_NULL;
      x_q     <= '0;
      y_q     <= '0;
      f_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fd_q    <= 1'b0;
    end else if (clr) begin
      dir_q <= DIR_NULL;
      x_q   <= '0;
      y_q   <= '0;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= last && (x_q == X_MAX) && (y_q == Y_MAX);
      if (accept) begin
        dir_q   <= DIR_NULL;
        f_q     <= f_in >> DATA_W;
        wdata_q <= f_in[DATA_W-1:0];
        addr_q  <= {a_plane, a_y, a_x};
      end else if (wr_ok) begin
        dir_q   <= dir_nx;
        f_q     <= f_q >> DATA_W;
        wdata_q <= f_q[DATA_W-1:0];
        addr_q  <= {a_plane, a_y, a_x};
        if (last) begin
          if (x_q == X_MAX) begin
            x_q <= '0;
            y_q <= (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
          end else begin
            x_q <= x_q + X_W'(1);
          end
        end
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign frame_done = fd_q;
  assign cell_x     = x_q;
  assign cell_y     = y_q;

endmodule

// File: tb/tb_lbm_streamer.sv
// Directed/randomised bench for lbm_streamer on a 4x4 lattice,
// checked against a lattice-arithmetic reference model.
module tb_lbm_streamer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 16;
  localparam int AW = 4 + YW + XW;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic           in_valid;
  logic           in_ready;
  logic [9*DW-1:0] f_in;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ready;
  logic           busy;
  logic           frame_done;
  logic [XW-1:0]  cell_x;
  logic [YW-1:0]  cell_y;

  int checks = 0;
  int errors = 0;
  int ex = 0;
  int ey = 0;
  int writes = 0;

  int dxs[9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  int dys[9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
  int opp[9] = '{0, 5, 6, 7, 8, 1, 2, 3, 4};

  lbm_streamer #(
    .GRID_W (W),
    .GRID_H (H),
    .X_W    (XW),
    .Y_W    (YW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .f_in       (f_in),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .cell_x     (cell_x),
    .cell_y     (cell_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int x, input int y,
                                             input int d);
    int nx;
    int ny;
    int p;
    nx = x + dxs[d];
    ny = y + dys[d];
    p  = d;
`ifdef LBM_STREAMER_BOUNCE_BACK_EN
    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
      nx = x;
      ny = y;
      p  = opp[d];
    end
`else
    nx = (nx + W) % W;
    ny = (ny + H) % H;
`endif
    return AW'(p * 16 + ny * 4 + nx);
  endfunction

  function automatic logic [9*DW-1:0] rnd_f();
    logic [9*DW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic send_cell(input logic [9*DW-1:0] f, input int stall_dir,
                           input int stall_n, input bit rnd,
                           input int abort_dir, output int wcyc);
    int d;
    int cyc;
    int st;
    bit last;
    wcyc = 0;
    chk("idle_in_ready", in_ready, 1);
    chk("cell_x", cell_x, ex);
    chk("cell_y", cell_y, ey);
    in_valid = 1'b1;
    f_in     = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    f_in     = rnd_f();
    d = 0; st = 0; cyc = 0;
    while (d < 9 && cyc < 60) begin
      if (d == abort_dir) begin
        mem_ready = 1'b0;
        return;
      end
      if (d == stall_dir && st < stall_n) begin
        mem_ready = 1'b0;
        st++;
      end else begin
        mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      chk("mem_we", mem_we, 1);
      chk("busy", busy, 1);
      chk("wr_in_ready", in_ready, 0);
      chk("mem_addr", mem_addr, exp_addr(ex, ey, d));
      chk("mem_wdata", mem_wdata, f[d*DW +: DW]);
      if (ex == 0 && ey == 0) begin
`ifdef LBM_STREAMER_BOUNCE_BACK_EN
        if (d == 6) chk("c0_d6_bb", mem_addr, 8'h20);
        if (d == 8) chk("c0_d8_bb", mem_addr, 8'h40);
`else
        if (d == 6) chk("c0_d6", mem_addr, 8'h6F);
        if (d == 8) chk("c0_d8", mem_addr, 8'h87);
`endif
        if (d == 0) chk("c0_d0", mem_addr, 8'h00);
        if (d == 3) chk("c0_d3", mem_addr, 8'h31);
      end
      wcyc++;
      @(posedge clk); #1;
      if (mem_ready) begin
        d++;
        writes++;
      end
      cyc++;
    end
    chk("write_budget", d, 9);
    mem_ready = 1'b1;
    last = (ex == W - 1) && (ey == H - 1);
    chk("frame_done", frame_done, last);
    chk("in_ready_back", in_ready, 1);
    chk("mem_we_low", mem_we, 0);
    if (ex == W - 1) begin
      ex = 0;
      ey = (ey == H - 1) ? 0 : ey + 1;
    end else begin
      ex++;
    end
    chk("raster_x", cell_x, ex);
    chk("raster_y", cell_y, ey);
  endtask

  initial begin
    int wc;
    logic [9*DW-1:0] f0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    mem_ready = 1'b1; f_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cell_x", cell_x, 0);
    chk("rst_cell_y", cell_y, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    for (int i = 0; i < 9; i++) f0[i*DW +: DW] = DW'(16'h0100 + i);
`ifdef LBM_STREAMER_BOUNCE_BACK_EN
    f0[6*DW +: DW] = 16'h1234;
`endif
    writes = 0;
    send_cell(f0, -1, 0, 1'b0, -1, wc);
    chk("c0_wcycles", wc, 9);
    send_cell(rnd_f(), 4, 3, 1'b0, -1, wc);
    chk("stall_wcycles", wc, 12);
    for (int c = 2; c < 16; c++) send_cell(rnd_f(), -1, 0, 1'b1, -1, wc);
    chk("frame_writes", writes, 144);
    @(posedge clk); #1;
    chk("fd_one_cycle", frame_done, 0);

    for (int c = 0; c < 6; c++) send_cell(rnd_f(), -1, 0, 1'b1, -1, wc);
    chk("pre_rst_x", cell_x, 2);
    chk("pre_rst_y", cell_y, 1);
    send_cell(rnd_f(), -1, 0, 1'b0, 5, wc);
    #3 rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_cell_x", cell_x, 0);
    chk("arst_cell_y", cell_y, 0);
    chk("arst_addr", mem_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    mem_ready = 1'b1;
    ex = 0; ey = 0;
    send_cell(rnd_f(), -1, 0, 1'b0, -1, wc);

    send_cell(rnd_f(), -1, 0, 1'b0, 2, wc);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("clr_mem_we", mem_we, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_cell_x", cell_x, 0);
    mem_ready = 1'b1;
    ex = 0; ey = 0;

    for (int c = 0; c < 15; c++) send_cell(rnd_f(), -1, 0, 1'b1, -1, wc);
    send_cell(rnd_f(), -1, 0, 1'b0, 8, wc);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    chk("clr_last_fd", frame_done, 0);
    chk("clr_last_we", mem_we, 0);
    chk("clr_last_x", cell_x, 0);
    chk("clr_last_y", cell_y, 0);
    @(posedge clk); #1;
    chk("clr_last_fd2", frame_done, 0);
    mem_ready = 1'b1;
    ex = 0; ey = 0;
    send_cell(rnd_f(), -1, 0, 1'b1, -1, wc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbm_streamer.md
Name: lbm_streamer

Overview:
- Downstream consumer of the collider's post-collision outputs: the writer end of the collide/stream pair.
- Accepts nine Q3.13 post-collision populations for one lattice cell per handshake.
- Propagates each population to its destination cell by writing it, one word per cycle, into a direction-planar lattice memory.
- Walks the grid in raster order and flags the end of each frame.

Parameters:
- DATA_W, 16, population word width (Q3.13).
- GRID_W, 64, lattice width in cells. Must satisfy GRID_W ≤ 2^X_W.
- GRID_H, 64, lattice height in cells. Must satisfy GRID_H ≤ 2^Y_W.
- X_W, 6, x coordinate width.
- Y_W, 6, y coordinate width.
- ADDR_W (localparam), 4+Y_W+X_W, memory address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear: forces IDLE and resets the raster to (0,0).
- in_valid  in  1  collider has a cell's populations ready.
- in_ready  out  1  streamer can accept a cell.
- f_in  in  9*DATA_W  populations, with f_in[DATA_W*i +: DATA_W] = direction i.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write address, {dir[3:0], y, x}.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high in WRITE.
- frame_done  out  1  one-cycle pulse after the last cell of a frame is fully written.
- cell_x  out  X_W  raster x of the cell being or next to be processed.
- cell_y  out  Y_W  raster y of the cell being or next to be processed.

Behaviour:
- Direction encoding (dx,dy), y positive = north: 0 null(0,0), 1 n(0,+1), 2 ne(+1,+1), 3 e(+1,0), 4 se(+1,-1), 5 s(0,-1), 6 sw(-1,-1), 7 w(-1,0), 8 nw(-1,+1).
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, cell_x=0, cell_y=0. Latched population data is cleared.
- State machine, two states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch f_in, set dir=0, go to WRITE.
  - WRITE: in_ready=0. mem_we=1 with registered mem_addr/mem_wdata for the current dir. On mem_ready, advance dir. When dir 8 is accepted, advance the raster and return to IDLE.
- Backpressure: while mem_ready=0, mem_we, mem_addr and mem_wdata stay stable and dir is held. No write is ever dropped or duplicated.
- Destination address: ((x+dx) mod GRID_W, (y+dy) mod GRID_H), i.e. periodic wrap. x=0 with dx=-1 gives GRID_W-1; x=GRID_W-1 with dx=+1 gives 0. Same rule for y. The wrap is a compare/select; no divider.
- Plane select: mem_addr = {dir, dest_y, dest_x}, so population i lands in plane i of its destination cell.
- Raster: x increments first, then y. After cell (GRID_W-1, GRID_H-1) completes, frame_done pulses for exactly one cycle (the cycle after the final write is accepted) and the raster returns to (0,0).
- Throughput: minimum 10 cycles per cell (1 accept + 9 writes). in_ready reasserts the cycle after the dir-8 write is accepted.
- clr takes priority over all transitions:
  - mem_we drops next cycle.
  - Any partially written cell is abandoned.
  - The raster resets to (0,0).
  - frame_done is not pulsed.
- rst mid-operation: all outputs go immediately (asynchronously) to their reset values. The partial cell is lost.
- Data path: values pass through unmodified. No arithmetic on populations.

Optional Feature:
- Macro: LBM_STREAMER_BOUNCE_BACK_EN.
- Defined: all four domain edges are half-way bounce-back walls. A population whose destination lies outside the grid is written to the source cell, in the plane of the opposite direction (1↔5, 2↔6, 3↔7, 4↔8). A corner cell's diagonal population that leaves the grid is reflected whole into the opposite diagonal.
- Undefined: periodic wrap as described in Behaviour.
- Cycle timing is identical in both builds.

Decomposition:
- Shared package lbm_pkg:
  - DATA_W.
  - Direction index localparams DIR_NULL..DIR_NW.
  - DX/DY lookup functions.
  - Opposite-direction function.
  - Q3.13 constants shared with the collider.
- Sub-module lbm_stream_addr: combinational (x, y, dir) → {dest plane, dest_x, dest_y}, containing the wrap and bounce-back logic. The top level keeps the FSM, raster counters and output registers.

Test Plan (GRID_W=GRID_H=4, X_W=Y_W=2 unless noted):
- Reset, then release → in_ready=1, mem_we=0, busy=0, frame_done=0, cell_x=cell_y=0.
- Cell (0,0), f_in dir i = 16'h0100+i, mem_ready=1 → 9 writes in consecutive cycles, including dir3 at addr {3,y0,x1} data 0x0103, dir6 at {6,y3,x3} data 0x0106, and dir8 at {8,y1,x3}. in_ready returns the next cycle.
- mem_ready=0 for 3 cycles while dir 4 is pending → mem_addr/mem_wdata held for 4 cycles, exactly one dir-4 write, total 12 write cycles.
- 16 back-to-back cells → 144 writes, frame_done high exactly one cycle after the 144th acceptance, raster back at (0,0).
- rst asserted mid-cycle during the dir-5 write of cell (2,1) → mem_we falls without waiting for clk. The next accepted cell writes dir0 to {0,y0,x0}.
- LBM_STREAMER_BOUNCE_BACK_EN defined, cell (0,0) dir6 = 16'h1234 → write {2,y0,x0} data 0x1234. Dir3 is still written to {3,y0,x1}.
